// File: rtl/sm4_pkg.sv
// Shared SM4 definitions used by the key schedule and the round datapath:
// system parameter FK, constant-key generator CK, rotation helper, FSM states.
package sm4_pkg;

  // System parameter FK0..FK3, XORed into the master key words on load
  localparam logic [31:0] FK [0:3] = '{
    32'hA3B1BAC6, 32'h56AA3350, 32'h677D9197, 32'hB27022DC
  };

  // Key-schedule controller states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // 32-bit circular left rotation, n in 1..31
  function automatic logic [31:0] rotl32(input logic [31:0] x, input int unsigned n);
    return (x << n) | (x >> (32 - n));
  endfunction

  // Round constant CK_i: byte j (byte 0 = MSB) is ((4i+j)*7) mod 256
  function automatic logic [31:0] ck(input logic [4:0] i);
    logic [31:0] w;
    w = '0;
    for (int j = 0; j < 4; j++) begin
      w[31-8*j -: 8] = 8'((int'(i) * 4 + j) * 7);
    end
    return w;
  endfunction

endpackage

// File: rtl/sbox_32b.sv
// SM4 non-linear substitution: four parallel 8-bit S-box lookups on a word.
module sbox_32b (
  input  logic [31:0] X_i,
  output logic [31:0] Y_o
);

  localparam logic [0:255][7:0] SBOX = {
    8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
    8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
    8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
    8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
    8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
    8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
    8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
    8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
    8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
    8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
    8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
    8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
    8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
    8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
    8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
    8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
  };

  for (genvar gi = 0; gi < 4; gi++) begin : g_byte
    assign Y_o[8*gi +: 8] = SBOX[X_i[8*gi +: 8]];
  end

endmodule

// File: rtl/sm4_keyexp.sv
// Iterative SM4 key schedule: one round key per clock, streamed out and kept
// in a 32-entry register bank with a combinational read port.
module sm4_keyexp
  import sm4_pkg::*;
#(
  parameter int NROUND  = 32,
  parameter bit DEC_ORD = 1'b0
) (
  input  logic         CLK_i,
  input  logic         RST_i,
  input  logic [127:0] KEY_i,
  input  logic         KEY_VALID_i,
  output logic         KEY_READY_o,
  output logic [31:0]  RK_o,
  output logic         RK_VALID_o,
  output logic [4:0]   RK_IDX_o,
  output logic         DONE_o,
  output logic         BANK_VALID_o,
  input  logic [4:0]   RD_IDX_i,
  output logic [31:0]  RD_RK_o
);

  localparam logic [4:0] LAST = 5'(NROUND - 1);

  state_t      state_reg;
  logic [4:0]  cnt_reg;
  logic [31:0] k_reg [0:3];
  logic        key_ready_reg;
  logic [31:0] rk_reg;
  logic        rk_valid_reg;
  logic [4:0]  rk_idx_reg;
  logic        done_reg;
  logic        bank_valid_reg;
  logic [31:0] bank [0:NROUND-1];

  logic        accept;
  logic [31:0] sbox_in;
  logic [31:0] sbox_out;
  logic [31:0] lin;
  logic [31:0] rk_next;
  logic [4:0]  rd_sel;

  assign accept = KEY_VALID_i & key_ready_reg;

  // Round function on the current key window {K0..K3}
  assign sbox_in = k_reg[1] ^ k_reg[2] ^ k_reg[3] ^ ck(cnt_reg);

  sbox_32b u_sbox (
    .X_i (sbox_in),
    .Y_o (sbox_out)
  );

  assign lin     = sbox_out ^ rotl32(sbox_out, 13) ^ rotl32(sbox_out, 23);
  assign rk_next = k_reg[0] ^ lin;

  // Controller, key window and streaming outputs
  always_ff @(posedge CLK_i or posedge RST_i) begin
    if (RST_i) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      k_reg[0]       <= '0;
      k_reg[1]       <= '0;
      k_reg[2]       <= '0;
      k_reg[3]       <= '0;
      key_ready_reg  <= 1'b1;
      rk_reg         <= '0;
      rk_valid_reg   <= 1'b0;
      rk_idx_reg     <= '0;
      done_reg       <= 1'b0;
      bank_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        RUN: begin
          k_reg[0]     <= k_reg[1];
          k_reg[1]     <= k_reg[2];
          k_reg[2]     <= k_reg[3];
          k_reg[3]     <= rk_next;
          rk_reg       <= rk_next;
          rk_idx_reg   <= cnt_reg;
          rk_valid_reg <= 1'b1;
          if (cnt_reg == LAST) begin
            // Ready stays low through the DONE_o cycle; it rises one edge later
            state_reg      <= DONE;
            done_reg       <= 1'b1;
            bank_valid_reg <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + 5'd1;
          end
        end
        default: begin
          // IDLE and DONE: RK_o/RK_IDX_o hold, only the strobes drop
          rk_valid_reg <= 1'b0;
          done_reg     <= 1'b0;
          if (accept) begin
            k_reg[0]       <= KEY_i[127:96] ^ FK[0];
            k_reg[1]       <= KEY_i[95:64]  ^ FK[1];
            k_reg[2]       <= KEY_i[63:32]  ^ FK[2];
            k_reg[3]       <= KEY_i[31:0]   ^ FK[3];
            cnt_reg        <= '0;
            bank_valid_reg <= 1'b0;
            key_ready_reg  <= 1'b0;
            state_reg      <= RUN;
          end else begin
            key_ready_reg <= 1'b1;
          end
        end
      endcase
    end
  end

  // Round-key bank write; contents are not reset, BANK_VALID_o qualifies them
  always_ff @(posedge CLK_i) begin
    if (state_reg == RUN) begin
      bank[cnt_reg] <= rk_next;
    end
  end

  // Decrypt order simply reverses the index (31 - idx == ~idx on 5 bits)
  assign rd_sel  = DEC_ORD ? ~RD_IDX_i : RD_IDX_i;
  assign RD_RK_o = bank[rd_sel];

  assign KEY_READY_o  = key_ready_reg;
  assign RK_o         = rk_reg;
  assign RK_VALID_o   = rk_valid_reg;
  assign RK_IDX_o     = rk_idx_reg;
  assign DONE_o       = done_reg;
  assign BANK_VALID_o = bank_valid_reg;

endmodule

// File: tb/tb_sm4_keyexp.sv
// Directed bench for sm4_keyexp: reset, standard vector, bank-driven
// encrypt/decrypt, held offers, mid-run reset and back-to-back keys.
module tb_sm4_keyexp;

  localparam logic [127:0] STD_KEY = 128'h0123456789ABCDEFFEDCBA9876543210;
  localparam logic [127:0] STD_CT  = 128'h681EDF34D206965E86B3E94F536E4246;
  localparam logic [127:0] KEY_A   = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [127:0] KEY_B   = 128'hFEDCBA98765432100123456789ABCDEF;

  localparam logic [0:255][7:0] SBOX = {
    8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
    8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
    8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
    8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
    8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
    8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
    8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
    8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
    8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
    8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
    8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
    8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
    8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
    8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
    8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
    8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
  };

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [127:0] key = '0;
  logic         key_valid = 1'b0;
  logic [4:0]   rd_idx = '0;

  logic         key_ready, rk_valid, done, bank_valid;
  logic [31:0]  rk, rd_rk;
  logic [4:0]   rk_idx;
  logic         d_key_ready, d_rk_valid, d_done, d_bank_valid;
  logic [31:0]  d_rk, d_rd_rk;
  logic [4:0]   d_rk_idx;

  int           n_checks = 0;
  int           n_fail = 0;
  logic [31:0]  exp_rk [0:31];

  always #5 clk = ~clk;

  sm4_keyexp #(.NROUND(32), .DEC_ORD(1'b0)) dut (
    .CLK_i(clk), .RST_i(rst), .KEY_i(key), .KEY_VALID_i(key_valid),
    .KEY_READY_o(key_ready), .RK_o(rk), .RK_VALID_o(rk_valid), .RK_IDX_o(rk_idx),
    .DONE_o(done), .BANK_VALID_o(bank_valid), .RD_IDX_i(rd_idx), .RD_RK_o(rd_rk)
  );

  sm4_keyexp #(.NROUND(32), .DEC_ORD(1'b1)) dut_dec (
    .CLK_i(clk), .RST_i(rst), .KEY_i(key), .KEY_VALID_i(key_valid),
    .KEY_READY_o(d_key_ready), .RK_o(d_rk), .RK_VALID_o(d_rk_valid), .RK_IDX_o(d_rk_idx),
    .DONE_o(d_done), .BANK_VALID_o(d_bank_valid), .RD_IDX_i(rd_idx), .RD_RK_o(d_rd_rk)
  );

  // Single comparison point: counts and reports mismatches
  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] tau(input logic [31:0] a);
    return {SBOX[a[31:24]], SBOX[a[23:16]], SBOX[a[15:8]], SBOX[a[7:0]]};
  endfunction

  function automatic logic [31:0] rl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  // Reference key schedule into exp_rk
  task automatic build_exp(input logic [127:0] mk);
    logic [31:0] kk [0:35];
    logic [31:0] ckw;
    logic [31:0] t;
    kk[0] = mk[127:96] ^ 32'hA3B1BAC6;
    kk[1] = mk[95:64]  ^ 32'h56AA3350;
    kk[2] = mk[63:32]  ^ 32'h677D9197;
    kk[3] = mk[31:0]   ^ 32'hB27022DC;
    for (int i = 0; i < 32; i++) begin
      for (int j = 0; j < 4; j++) ckw[31-8*j -: 8] = 8'((4 * i + j) * 7);
      t = tau(kk[i+1] ^ kk[i+2] ^ kk[i+3] ^ ckw);
      kk[i+4] = kk[i] ^ t ^ rl(t, 13) ^ rl(t, 23);
      exp_rk[i] = kk[i+4];
    end
  endtask

  // 32 SM4 rounds using the bank read port of either instance
  task automatic run_cipher(input logic [127:0] din, input bit use_dec, output logic [127:0] dout);
    logic [31:0] x [0:35];
    logic [31:0] t;
    logic [31:0] rkw;
    x[0] = din[127:96]; x[1] = din[95:64]; x[2] = din[63:32]; x[3] = din[31:0];
    for (int i = 0; i < 32; i++) begin
      rd_idx = 5'(i);
      #1;
      rkw = use_dec ? d_rd_rk : rd_rk;
      t = tau(x[i+1] ^ x[i+2] ^ x[i+3] ^ rkw);
      x[i+4] = x[i] ^ t ^ rl(t, 2) ^ rl(t, 10) ^ rl(t, 18) ^ rl(t, 24);
    end
    dout = {x[35], x[34], x[33], x[32]};
  endtask

  // Called at a negedge; returns just after the accepting edge
  task automatic offer_key(input logic [127:0] k, input bit hold);
    int w;
    w = 0;
    key = k;
    key_valid = 1'b1;
    while (!key_ready && w < 60) begin
      @(negedge clk);
      w++;
    end
    check_eq("offer ready", 128'(key_ready), 128'(1'b1));
    @(posedge clk);
    #1;
    if (!hold) key_valid = 1'b0;
  endtask

  // Checks the 32-key stream against exp_rk; exits at the negedge after the stream
  task automatic collect(input string tag, input int budget);
    int w;
    w = 0;
    @(negedge clk);
    while (!rk_valid && w < budget) begin
      @(negedge clk);
      w++;
    end
    check_eq({tag, " first valid"}, 128'(rk_valid), 128'(1'b1));
    if (rk_valid) begin
      for (int i = 0; i < 32; i++) begin
        check_eq($sformatf("%s valid%0d", tag, i), 128'(rk_valid), 128'(1'b1));
        check_eq($sformatf("%s idx%0d", tag, i), 128'(rk_idx), 128'(i));
        check_eq($sformatf("%s rk%0d", tag, i), 128'(rk), 128'(exp_rk[i]));
        check_eq($sformatf("%s done%0d", tag, i), 128'(done), 128'(i == 31));
        check_eq($sformatf("%s ready%0d", tag, i), 128'(key_ready), 128'(1'b0));
        @(negedge clk);
      end
      check_eq({tag, " valid low after 32"}, 128'(rk_valid), 128'(1'b0));
      check_eq({tag, " done low"}, 128'(done), 128'(1'b0));
      check_eq({tag, " bank valid"}, 128'(bank_valid), 128'(1'b1));
      check_eq({tag, " rk hold"}, 128'(rk), 128'(exp_rk[31]));
      check_eq({tag, " idx hold"}, 128'(rk_idx), 128'(5'd31));
      check_eq({tag, " ready in done"}, 128'(key_ready), 128'(1'b1));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] ct;
    logic [127:0] pt;
    int w;

    // Test 1: async reset before any clock edge
    #1 rst = 1'b1;
    #1;
    check_eq("rst ready", 128'(key_ready), 128'(1'b1));
    check_eq("rst rk", 128'(rk), 128'(0));
    check_eq("rst valid", 128'(rk_valid), 128'(1'b0));
    check_eq("rst idx", 128'(rk_idx), 128'(0));
    check_eq("rst done", 128'(done), 128'(1'b0));
    check_eq("rst bank valid", 128'(bank_valid), 128'(1'b0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    $display("T1 reset checked");

    // Test 2: standard vector
    build_exp(STD_KEY);
    offer_key(STD_KEY, 1'b0);
    collect("std", 1);
    check_eq("std rk31 const", 128'(rk), 128'(32'h9124A012));
    check_eq("dec inst rk31", 128'(d_rk), 128'(32'h9124A012));
    check_eq("dec inst idx", 128'(d_rk_idx), 128'(5'd31));
    check_eq("dec inst valid", 128'(d_rk_valid), 128'(1'b0));
    check_eq("dec inst done", 128'(d_done), 128'(1'b0));
    check_eq("dec inst ready", 128'(d_key_ready), 128'(1'b1));
    check_eq("dec inst bank valid", 128'(d_bank_valid), 128'(1'b1));
    $display("T2 standard key stream checked");

    // Test 3: bank read port, encrypt and decrypt
    rd_idx = 5'd0;
    #1;
    check_eq("bank rk0", 128'(rd_rk), 128'(32'hF12186F9));
    check_eq("dec bank idx0", 128'(d_rd_rk), 128'(32'h9124A012));
    rd_idx = 5'd31;
    #1;
    check_eq("bank rk31", 128'(rd_rk), 128'(32'h9124A012));
    run_cipher(STD_KEY, 1'b0, ct);
    check_eq("encrypt", ct, STD_CT);
    run_cipher(STD_CT, 1'b1, pt);
    check_eq("decrypt", pt, STD_KEY);
    $display("T3 cipher through bank: ct=%h pt=%h", ct, pt);

    // Test 4: second key offered and held during RUN
    @(negedge clk);
    build_exp(KEY_A);
    offer_key(KEY_A, 1'b1);
    key = KEY_B;
    collect("held A", 1);
    build_exp(KEY_B);
    @(negedge clk);
    key_valid = 1'b0;
    check_eq("held B accepted", 128'(key_ready), 128'(1'b0));
    check_eq("held B bank invalid", 128'(bank_valid), 128'(1'b0));
    collect("held B", 0);
    $display("T4 held offer checked");

    // Test 5: reset at cnt=10, then rerun of the standard key
    build_exp(STD_KEY);
    offer_key(STD_KEY, 1'b0);
    w = 0;
    while (!(rk_valid && rk_idx == 5'd9) && w < 40) begin
      @(negedge clk);
      w++;
    end
    check_eq("reach rk9", 128'(rk_idx), 128'(5'd9));
    #2 rst = 1'b1;
    #1;
    check_eq("midrun rst ready", 128'(key_ready), 128'(1'b1));
    check_eq("midrun rst valid", 128'(rk_valid), 128'(1'b0));
    check_eq("midrun rst rk", 128'(rk), 128'(0));
    check_eq("midrun rst idx", 128'(rk_idx), 128'(0));
    check_eq("midrun rst bank valid", 128'(bank_valid), 128'(1'b0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("post rst idle valid", 128'(rk_valid), 128'(1'b0));
    offer_key(STD_KEY, 1'b0);
    collect("rerun", 1);
    $display("T5 mid-run reset checked");

    // Test 6: back-to-back all-zero then all-ones
    build_exp('0);
    offer_key('0, 1'b0);
    collect("zeros", 1);
    build_exp('1);
    offer_key('1, 1'b0);
    collect("ones", 1);
    $display("T6 back-to-back keys checked");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
